dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the data memory; port 0 is the data-side requester, port 1 the fetch/refill requester.
- Serialises block reads and writes: latches one request, drives the memory strobes for one cycle, waits the memory latency, returns the block and a one-cycle ack.
- Owns the end-of-run flush: drains the in-flight transaction, then raises the memory flush line.

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_rr_pick2.sv | 17 +
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared sizes and sequencer state encoding for the data-memory arbiter
package dmem_arbiter_pkg;

  localparam int WORD_SIZE     = 32;
  localparam int BLOCK_SIZE    = 512;
  localparam int BYTE_SIZE     = 8;
  localparam int DATA_MEM_SIZE = 4096;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - two-input round-robin picker, purely combinational
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_id,
  output logic       gnt_valid
);

  // A lone requester wins; on a tie the requester not served last wins
  always_comb begin
    gnt_valid = |req;
    gnt_id    = 1'b0;
    if (req == 2'b11) gnt_id = ~last_gnt;
    else              gnt_id = req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter and block-transfer sequencer in front of the data memory
module dmem_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 512,
  parameter int MEM_LAT    = 1,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [WORD_SIZE-1:0]  addr0,
  input  logic [WORD_SIZE-1:0]  addr1,
  input  logic [BLOCK_SIZE-1:0] wdata0,
  input  logic [BLOCK_SIZE-1:0] wdata1,
  output logic [1:0]            ack,
  output logic                  err,
  output logic [BLOCK_SIZE-1:0] rdata,
  input  logic                  flush_req,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic                  mem_readable,
  output logic                  mem_writable,
  output logic [BLOCK_SIZE-1:0] mem_write,
  input  logic [BLOCK_SIZE-1:0] mem_out1,
  output logic                  mem_flush
);
  import dmem_arbiter_pkg::*;

  // Range arithmetic is one bit wider than an address so addr + block length cannot wrap
  localparam int                 XFER_BYTES = BLOCK_SIZE / BYTE_SIZE;
  localparam logic [WORD_SIZE:0] XFER_LEN   = (WORD_SIZE + 1)'(XFER_BYTES);
  localparam logic [WORD_SIZE:0] MEM_LIMIT  = (WORD_SIZE + 1)'(MEM_BYTES);

  state_t     state;
  logic       id_q;
  logic       we_q;
  logic       err_q;
  logic       last_gnt;
  logic [3:0] cnt;

  logic                  gnt_id;
  logic                  gnt_valid;
  logic [WORD_SIZE-1:0]  gnt_addr;
  logic [BLOCK_SIZE-1:0] gnt_wdata;
  logic                  gnt_we;
  logic                  gnt_oor;

  rr_pick2 u_pick (
    .req       (req),
    .last_gnt  (last_gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // Select the winning requester's fields and range-check its block
  always_comb begin
    gnt_addr  = gnt_id ? addr1 : addr0;
    gnt_wdata = gnt_id ? wdata1 : wdata0;
    gnt_we    = we[gnt_id];
    gnt_oor   = ({1'b0, gnt_addr} + XFER_LEN) > MEM_LIMIT;
  end

  // Sequencer: grant, one-cycle strobe, latency wait, one-cycle ack; flush is terminal.
  // Strobes are loaded at grant so they are high exactly during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      id_q         <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      last_gnt     <= 1'b1;
      cnt          <= 4'd0;
      ack          <= 2'b00;
      err          <= 1'b0;
      rdata        <= '0;
      mem_addr     <= '0;
      mem_write    <= '0;
      mem_readable <= 1'b0;
      mem_writable <= 1'b0;
      mem_flush    <= 1'b0;
    end else begin
      ack          <= 2'b00;
      err          <= 1'b0;
      mem_readable <= 1'b0;
      mem_writable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (flush_req) begin
            mem_flush <= 1'b1;
            state     <= S_FLUSH;
          end else if (gnt_valid) begin
            id_q         <= gnt_id;
            we_q         <= gnt_we;
            err_q        <= gnt_oor;
            mem_addr     <= gnt_addr;
            mem_write    <= gnt_wdata;
            mem_readable <= !gnt_we && !gnt_oor;
            mem_writable <= gnt_we && !gnt_oor;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (err_q) begin
            state <= S_RESP;
          end else begin
            cnt   <= 4'(MEM_LAT);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!we_q) rdata <= mem_out1;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          ack      <= id_q ? 2'b10 : 2'b01;
          err      <= err_q;
          last_gnt <= id_q;
          err_q    <= 1'b0;
          state    <= S_IDLE;
        end
        S_FLUSH: begin
          mem_flush <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req, we, ack;
  logic [31:0]  addr0, addr1, mem_addr;
  logic [511:0] wdata0, wdata1, rdata, mem_write, mem_out1;
  logic         err, flush_req, mem_readable, mem_writable, mem_flush;
  logic         mem_load;

  dmem_arbiter #(
    .WORD_SIZE(32), .BLOCK_SIZE(512), .MEM_LAT(1), .MEM_BYTES(4096)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .ack(ack), .err(err), .rdata(rdata),
    .flush_req(flush_req), .mem_addr(mem_addr), .mem_readable(mem_readable),
    .mem_writable(mem_writable), .mem_write(mem_write), .mem_out1(mem_out1),
    .mem_flush(mem_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] init_block(input int i);
    logic [7:0] b;
    b = 8'(i) ^ 8'h5A;
    if (i == 2) b = 8'hAB;
    return {64{b}};
  endfunction

  // Environment memory, one-cycle read latency, aligned by block index
  logic [511:0] mem_arr [64];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_block(i);
    end else begin
      if (mem_readable) mem_out1 <= mem_arr[mem_addr[11:6]];
      if (mem_writable) mem_arr[mem_addr[11:6]] <= mem_write;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] a;
    logic [7:0]  wbyte;
    logic        exp_err;
    logic [7:0]  exp_rbyte;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t tbl [8];

  logic [511:0] model_mem [64];
  logic [511:0] model_rdata;
  logic         last_served;
  logic [1:0]   hist [0:1023];
  logic         pend [2];
  int           start [2];
  logic         pwe [2];
  logic [31:0]  pad [2];
  logic [511:0] pwd [2];

  initial begin
    logic [511:0] wd;
    int lat, nrd, nwr, nack, g, prev_ack, gexp, r, seen_flush, k0;
    logic got, p, oor;
    logic [1:0] exp_seq [4];

    tbl[0] = '{1'b0, 1'b0, 32'h0000_0080, 8'h00, 1'b0, 8'hAB, 3, 1, 0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0100, 8'h11, 1'b0, 8'hAB, 3, 0, 1};
    tbl[2] = '{1'b0, 1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h11, 3, 1, 0};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_0FC0, 8'h00, 1'b0, 8'h65, 3, 1, 0};
    tbl[4] = '{1'b0, 1'b0, 32'h0000_1000, 8'h00, 1'b1, 8'h65, 2, 0, 0};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0FC1, 8'h00, 1'b1, 8'h65, 2, 0, 0};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0000, 8'h00, 1'b0, 8'h5A, 3, 1, 0};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_1000, 8'h77, 1'b1, 8'h5A, 2, 0, 0};

    rst_n = 1'b0; req = 2'b00; we = 2'b00; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; flush_req = 1'b0; mem_load = 1'b1;
    step();
    check("rst_ack", ack, 2'b00);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_strobes", {mem_readable, mem_writable, mem_flush}, 3'b000);
    step();
    mem_load = 1'b0;
    rst_n = 1'b1;
    step();

    // Single transactions from the vector table
    for (int i = 0; i < 8; i++) begin
      wd = {64{tbl[i].wbyte}};
      if (tbl[i].port) begin
        addr1 = tbl[i].a; wdata1 = wd; we[1] = tbl[i].wr; req = 2'b10;
      end else begin
        addr0 = tbl[i].a; wdata0 = wd; we[0] = tbl[i].wr; req = 2'b01;
      end
      lat = -1; nrd = 0; nwr = 0; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        step();
        if (mem_readable) nrd++;
        if (mem_writable) nwr++;
        if (ack != 2'b00) begin
          got = 1'b1;
          lat = k;
          check($sformatf("tbl%0d_ack", i), ack, tbl[i].port ? 2'b10 : 2'b01);
          check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
          check($sformatf("tbl%0d_rdata", i), rdata, {64{tbl[i].exp_rbyte}});
        end
      end
      req = 2'b00;
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      check($sformatf("tbl%0d_rd_pulses", i), nrd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_wr_pulses", i), nwr, tbl[i].exp_wr);
      step();
    end

    // Both requesters held high after reset: grants alternate 0,1,0,1, one ack per 4 cycles
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    addr0 = 32'h40; addr1 = 32'h80; we = 2'b00; req = 2'b11;
    nack = 0; k0 = 0;
    for (int k = 1; k <= 30 && nack < 4; k++) begin
      step();
      if (ack != 2'b00) begin
        check($sformatf("alt%0d_ack", nack), ack, exp_seq[nack]);
        check($sformatf("alt%0d_spacing", nack), k - k0, 4);
        check($sformatf("alt%0d_rdata", nack), rdata, ack[1] ? {64{8'hAB}} : {64{8'h5B}});
        k0 = k;
        nack++;
      end
    end
    req = 2'b00;
    check("alt_ack_count", nack, 4);
    step(); step();

    // Flush raised during the WAIT of a port-1 read
    addr1 = 32'h40; we = 2'b00; req = 2'b10;
    step(); step();
    flush_req = 1'b1;
    step(); step();
    check("flush_read_ack", ack, 2'b10);
    check("flush_ack_cycle_idle", mem_flush, 1'b0);
    req = 2'b00;
    step();
    check("flush_raised", mem_flush, 1'b1);
    req = 2'b01; addr0 = 32'h0;
    nack = 0; seen_flush = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ack != 2'b00) nack++;
      if (mem_flush) seen_flush++;
    end
    check("flush_no_grant", nack, 0);
    check("flush_held", seen_flush, 12);
    req = 2'b00; flush_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_drops_flush", {mem_flush, ack}, 3'b000);
    #2 rst_n = 1'b1;
    step();

    // Reset pulsed during WAIT aborts the transaction without an ack
    addr0 = 32'h80; we = 2'b00; req = 2'b01;
    step();
    check("issue_read_strobe", mem_readable, 1'b1);
    step();
    #2 rst_n = 1'b0;
    #1 check("rst_wait_outputs", {mem_readable, mem_writable, ack, mem_flush}, 5'b0);
    req = 2'b00;
    #2 rst_n = 1'b1;
    nack = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (ack != 2'b00) nack++;
    end
    check("aborted_no_ack", nack, 0);
    addr0 = 32'hC0; req = 2'b01;
    lat = -1; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (ack != 2'b00) begin
        got = 1'b1; lat = k;
        check("post_rst_ack", ack, 2'b01);
        check("post_rst_rdata", rdata, {64{8'h59}});
      end
    end
    req = 2'b00;
    check("post_rst_latency", lat, 3);

    // Randomised traffic against a transaction-level model
    rst_n = 1'b0; mem_load = 1'b1;
    step();
    rst_n = 1'b1; mem_load = 1'b0;
    step();
    for (int i = 0; i < 64; i++) model_mem[i] = init_block(i);
    model_rdata = '0;
    last_served = 1'b1;
    prev_ack = 0;
    for (int q = 0; q < 2; q++) begin pend[q] = 1'b0; start[q] = 0; end
    for (int n = 0; n < 700; n++) begin
      if (n > 0) step();
      if (ack != 2'b00) begin
        check("rnd_ack_onehot", $countones(ack), 1);
        p = ack[1];
        check("rnd_ack_pending", pend[p], 1'b1);
        if (pend[p]) begin
          oor = ({32'b0, pad[p]} + 64'd64) > 64'd4096;
          g = n - (oor ? 2 : 3);
          gexp = (prev_ack > start[p]) ? prev_ack + 1 : start[p] + 1;
          check("rnd_grant_time", g, gexp);
          if (g >= 1 && g - 1 <= n && hist[g-1] == 2'b11) check("rnd_rr_fair", p, !last_served);
          check("rnd_err", err, oor);
          if (!oor) begin
            if (pwe[p]) model_mem[pad[p][11:6]] = pwd[p];
            else        model_rdata = model_mem[pad[p][11:6]];
          end
          check("rnd_rdata", rdata, model_rdata);
          last_served = p;
          prev_ack = n;
          pend[p] = 1'b0;
        end
      end
      for (int q = 0; q < 2; q++) begin
        if (pend[q] && n - start[q] > 30) begin
          check($sformatf("rnd_timeout_port%0d", q), 1'b0, 1'b1);
          pend[q] = 1'b0;
        end
        if (!pend[q] && n < 600 && $urandom_range(0, 3) == 0) begin
          pend[q] = 1'b1;
          start[q] = n;
          pwe[q] = 1'($urandom_range(0, 1));
          r = $urandom_range(0, 9);
          if (r < 7)      pad[q] = 32'($urandom_range(0, 4095));
          else if (r < 9) pad[q] = 32'hFC0 + 32'($urandom_range(0, 63));
          else            pad[q] = $urandom();
          for (int w = 0; w < 16; w++) pwd[q][w*32 +: 32] = $urandom();
        end
      end
      addr0 = pad[0]; we[0] = pwe[0]; wdata0 = pwd[0];
      addr1 = pad[1]; we[1] = pwe[1]; wdata1 = pwd[1];
      req = {pend[1], pend[0]};
      hist[n] = req;
    end
    check("rnd_drained", {pend[1], pend[0]}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
